// File: rtl/skid_pipeline.sv
// Multi-stage valid/ready register slice. Each stage is a 2-entry skid buffer
// whose outputs (valid, data, ready) all come straight from flops, so there is
// no combinational path through the block in either direction.

module skid_stage #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  accept;
  logic                  take;
  logic                  load_main;
  logic                  load_skid;
  logic                  main_from_skid;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  // Next-state and register-load decode for the skid buffer.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    accept         = in_valid && in_ready_q;
    take           = out_valid_q && out_ready;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept && take) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (take) begin
          state_d   = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (take) begin
          main_from_skid = 1'b1;
          state_d        = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State, handshake flops and data registers; ready lags freed space by one edge.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
      if (load_main) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

module skid_pipeline #(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned NUM_STAGES = 8,
  localparam int unsigned CNT_WIDTH  = $clog2(2 * NUM_STAGES + 1)
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic [CNT_WIDTH-1:0]  occupancy
);

  if (NUM_STAGES < 1) begin : g_bad_cfg
    $error("skid_pipeline: NUM_STAGES must be >= 1");
  end

  logic [DATA_WIDTH-1:0] stg_data [NUM_STAGES+1];
  logic [NUM_STAGES:0]   stg_valid;
  logic [NUM_STAGES:0]   stg_ready;
  logic [CNT_WIDTH-1:0]  occ_q;
  logic                  in_xfer;
  logic                  out_xfer;

  assign stg_data[0]           = data_in;
  assign stg_valid[0]          = data_in_valid;
  assign data_in_ready         = stg_ready[0];
  assign data_out              = stg_data[NUM_STAGES];
  assign data_out_valid        = stg_valid[NUM_STAGES];
  assign stg_ready[NUM_STAGES] = data_out_ready;
  assign occupancy             = occ_q;

  assign in_xfer  = data_in_valid && stg_ready[0];
  assign out_xfer = stg_valid[NUM_STAGES] && data_out_ready;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    skid_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk_i    (clk_i),
      .arst_i   (arst_i),
      .in_data  (stg_data[k]),
      .in_valid (stg_valid[k]),
      .in_ready (stg_ready[k]),
      .out_data (stg_data[k+1]),
      .out_valid(stg_valid[k+1]),
      .out_ready(stg_ready[k+1])
    );
  end

  // Word count: bounded by construction since the chain never accepts past capacity.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      occ_q <= '0;
    end else begin
      unique case ({in_xfer, out_xfer})
        2'b10:   occ_q <= occ_q + CNT_WIDTH'(1);
        2'b01:   occ_q <= occ_q - CNT_WIDTH'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule
